irq_capture4: RTL

- Sequential front end for the 4-line priority encoder stage.
- Synchronises four asynchronous request lines, detects events, and holds them in a pending register.
- Exposes the pending vector plus enable directly to the encoder stage.
- Also issues one request id at a time over a valid/ready handshake, clearing the served bit on accept.
- Priority matches the encoder: bit 3 highest, bit 0 lowest.

---
 rtl/irq_capture4.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/irq_capture4.sv
// Request capture front end: input synchronisers, edge/level event detection, pending and
// overflow registers, and a valid/ready id issuer. Optional timestamping via IRQ_CAPTURE_TIMESTAMP_EN.
module irq_capture4 #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] irq_in,
  input  logic [3:0] mask,
  input  logic       en,
  output logic [3:0] pend,
  output logic       irq_valid,
  output logic [1:0] irq_id,
  input  logic       irq_ready,
  output logic [3:0] overflow,
  input  logic       clr_ovf
`ifdef IRQ_CAPTURE_TIMESTAMP_EN
  ,
  output logic [15:0] irq_ts
`endif
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic EDGE = (EDGE_MODE != 0);

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] s;
  logic [3:0] evt;

  state_t     state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] ovf_q, ovf_d;
  logic [1:0] id_q, id_d;
  logic [3:0] cand;
  logic [3:0] clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE) begin : g_edge
      localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);
      logic [3:0] s_d_q;
      logic [3:0] evt_q;
      logic [2:0] warm_q;
      logic       armed;

      // Edge detection stays disarmed until the synchroniser and history have refilled after
      // reset, so a line already high when reset releases does not look like a fresh rising edge.
      assign armed = (warm_q == WARM);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_d_q  <= '0;
          evt_q  <= '0;
          warm_q <= '0;
        end else begin
          s_d_q <= s;
          evt_q <= armed ? (s & ~s_d_q) : '0;
          if (!armed) warm_q <= warm_q + 3'd1;
        end
      end

      assign evt = evt_q;
    end else begin : g_level
      assign evt = s;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    cand    = pend_q & ~mask;

    case (state_q)
      IDLE: begin
        if (en && (cand != '0)) begin
          state_d = PRESENT;
          for (int unsigned b = 0; b < 4; b++) begin
            if (cand[b]) id_d = 2'(b);
          end
        end
      end
      PRESENT: begin
        if (irq_ready) begin
          clr[id_q] = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new event always wins over the accept-clear; only an event hitting an
    // uncleared pending bit counts as lost.
    pend_d = evt | (pend_q & ~clr);
    ovf_d  = ({4{EDGE}} & evt & pend_q & ~clr) | (ovf_q & ~{4{clr_ovf}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovf_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
    end
  end

  assign pend      = pend_q;
  assign overflow  = ovf_q;
  assign irq_id    = id_q;
  assign irq_valid = (state_q == PRESENT);

`ifdef IRQ_CAPTURE_TIMESTAMP_EN
  logic [15:0] ts_cnt_q;
  logic [15:0] irq_ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q <= '0;
      irq_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 16'd1;
      if ((state_q == IDLE) && (state_d == PRESENT)) irq_ts_q <= ts_cnt_q;
    end
  end

  assign irq_ts = irq_ts_q;
`endif

endmodule
